ahb_bridge_arbiter: RTL and testbench

AHB_BRIDGE_ARBITER -- requirements
Module: ahb_bridge_arbiter

---
 rtl/ahb_arb_pkg.sv | 28 ++
 rtl/ahb_bridge_arbiter_if.sv | 19 +
 rtl/ahb_bridge_arbiter_rr_picker.sv | 24 ++
 rtl/ahb_bridge_arbiter.sv | 109 ++++++++++
 tb/tb_ahb_bridge_arbiter.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/ahb_arb_pkg.sv
// Shared types and constants for the AHB bridge arbiter: FSM states,
// HTRANS encodings and default sizing.
package ahb_arb_pkg;

  typedef enum logic [1:0] {
    PARK   = 2'b00,
    OWN    = 2'b01,
    SWITCH = 2'b10
  } arb_state_e;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam int ARB_NUM_MASTERS = 4;
  localparam int ARB_MAX_BEATS   = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // NONSEQ and SEQ both have bit 1 set; IDLE and BUSY carry no data.
  function automatic logic is_xfer(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_bridge_arbiter_if.sv
// Request/grant bundle between the AHB requesters and the bridge arbiter.
// The arbiter connects through 'slave'; the requester side uses 'master'.
interface ahb_bridge_arbiter_if #(
  parameter int NUM_MASTERS = ahb_arb_pkg::ARB_NUM_MASTERS
) ();
  localparam int IDX_W = ahb_arb_pkg::idx_width(NUM_MASTERS);

  logic [NUM_MASTERS-1:0] Hreq;
  logic [1:0]             Htrans;
  logic                   Hreadyout;
  logic [NUM_MASTERS-1:0] Hgrant;
  logic [IDX_W-1:0]       Hmaster;
  logic                   grant_valid;

  modport slave  (input  Hreq, Htrans, Hreadyout,
                  output Hgrant, Hmaster, grant_valid);
  modport master (output Hreq, Htrans, Hreadyout,
                  input  Hgrant, Hmaster, grant_valid);
endinterface

// File: rtl/ahb_bridge_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request bit searching upward
// from last_i+1, wrapping back around to last_i itself.
module rr_picker #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [IDX_W-1:0] winner_o,
  output logic             any_req_o
);
  logic [IDX_W-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    winner_o  = '0;
    idx       = '0;
    any_req_o = |req_i;
    for (int i = N; i >= 1; i--) begin
      idx = IDX_W'((int'(last_i) + i) % N);
      if (req_i[idx]) winner_o = idx;
    end
  end
endmodule

// File: rtl/ahb_bridge_arbiter.sv
// AHB bridge arbiter: round-robin tenure grants with a beat budget, no
// mid-burst break, and a SWITCH drain cycle between owners. Outputs registered.
module ahb_bridge_arbiter import ahb_arb_pkg::*; #(
  parameter int NUM_MASTERS = ARB_NUM_MASTERS,
  parameter int MAX_BEATS   = ARB_MAX_BEATS
) (
  input logic                 Hclk,
  input logic                 Hresetn,
  ahb_bridge_arbiter_if.slave bus
);
  localparam int IDX_W = idx_width(NUM_MASTERS);
  localparam int BW    = $clog2(MAX_BEATS) + 1;

  arb_state_e             state_q;
  logic [IDX_W-1:0]       last_owner_q;
  logic [BW-1:0]          beat_q;
  logic [NUM_MASTERS-1:0] hgrant_q;
  logic [IDX_W-1:0]       hmaster_q;
  logic                   gvalid_q;

  logic [IDX_W-1:0]       winner;
  logic                   any_req;
  logic [BW-1:0]          beat_d;
  logic                   release_ok;

  function automatic logic [NUM_MASTERS-1:0] onehot(input logic [IDX_W-1:0] i);
    logic [NUM_MASTERS-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  rr_picker #(.N(NUM_MASTERS), .IDX_W(IDX_W)) u_rr (
    .req_i     (bus.Hreq),
    .last_i    (last_owner_q),
    .winner_o  (winner),
    .any_req_o (any_req)
  );

  // The beat completing this cycle counts toward the budget; saturate so a
  // runaway SEQ stream can never wrap back below MAX_BEATS.
  always_comb begin
    beat_d = beat_q;
    if (bus.Hreadyout && is_xfer(bus.Htrans) && (beat_q != '1))
      beat_d = beat_q + 1'b1;
    release_ok = bus.Hreadyout && (bus.Htrans != HTRANS_SEQ) &&
                 (!bus.Hreq[last_owner_q] || (beat_d >= BW'(MAX_BEATS)));
  end

  always_ff @(posedge Hclk or negedge Hresetn) begin
    if (!Hresetn) begin
      state_q      <= PARK;
      last_owner_q <= IDX_W'(NUM_MASTERS - 1);
      beat_q       <= '0;
      hgrant_q     <= onehot('0);
      hmaster_q    <= '0;
      gvalid_q     <= 1'b0;
    end else begin
      case (state_q)
        PARK: begin
          if (any_req && bus.Hreadyout) begin
            state_q      <= OWN;
            last_owner_q <= winner;
            beat_q       <= '0;
            hgrant_q     <= onehot(winner);
            hmaster_q    <= winner;
            gvalid_q     <= 1'b1;
          end
        end
        OWN: begin
          beat_q <= beat_d;
          if (release_ok) begin
            state_q  <= SWITCH;
            hgrant_q <= '0;
            gvalid_q <= 1'b0;
          end
        end
        SWITCH: begin
          // Hmaster keeps the old owner so its last data phase can drain.
          if (bus.Hreadyout) begin
            if (any_req) begin
              state_q      <= OWN;
              last_owner_q <= winner;
              beat_q       <= '0;
              hgrant_q     <= onehot(winner);
              hmaster_q    <= winner;
              gvalid_q     <= 1'b1;
            end else begin
              state_q   <= PARK;
              hgrant_q  <= onehot('0);
              hmaster_q <= '0;
            end
          end
        end
        default: begin
          state_q   <= PARK;
          hgrant_q  <= onehot('0);
          hmaster_q <= '0;
          gvalid_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Hgrant      = hgrant_q;
  assign bus.Hmaster     = hmaster_q;
  assign bus.grant_valid = gvalid_q;

endmodule

// File: tb/tb_ahb_bridge_arbiter.sv
// Bench for ahb_bridge_arbiter: tenure-level reference model checked every
// cycle, directed scenarios with literal tenure expectations, random traffic.
module tb_ahb_bridge_arbiter;
  import ahb_arb_pkg::*;

  localparam int NM   = 4;
  localparam int MAXB = 8;

  logic Hclk;
  logic Hresetn;
  int   nvec = 0;
  int   nerr = 0;

  ahb_bridge_arbiter_if #(.NUM_MASTERS(NM)) bus ();

  ahb_bridge_arbiter #(.NUM_MASTERS(NM), .MAX_BEATS(MAXB)) dut (
    .Hclk    (Hclk),
    .Hresetn (Hresetn),
    .bus     (bus.slave)
  );

  initial Hclk = 1'b0;
  always #5 Hclk = ~Hclk;

  // Reference model: who holds a tenure (-1 = nobody), whether a released
  // owner is still draining, the last owner and beats taken this tenure.
  int m_own = -1, m_prev = 0, m_last = NM - 1, m_beats = 0;
  bit m_drain = 1'b0;

  function automatic bit req_bit(input logic [NM-1:0] r, input int i);
    logic [NM-1:0] s;
    s = r >> i;
    return s[0];
  endfunction

  function automatic int rr(input logic [NM-1:0] r, input int last);
    for (int k = 1; k <= NM; k++) begin
      int m;
      m = (last + k) % NM;
      if (req_bit(r, m)) return m;
    end
    return -1;
  endfunction

  always @(posedge Hclk or negedge Hresetn) begin : model
    int own, prv, lst, bts, w;
    bit drn;
    if (!Hresetn) begin
      m_own <= -1; m_prev <= 0; m_last <= NM - 1; m_beats <= 0; m_drain <= 1'b0;
    end else begin
      own = m_own; prv = m_prev; lst = m_last; bts = m_beats; drn = m_drain;
      if (own >= 0) begin
        if (bus.Hreadyout && (bus.Htrans == HTRANS_NONSEQ || bus.Htrans == HTRANS_SEQ))
          bts = bts + 1;
        if (bus.Hreadyout && bus.Htrans != HTRANS_SEQ &&
            (!req_bit(bus.Hreq, own) || bts >= MAXB)) begin
          prv = own; own = -1; drn = 1'b1;
        end
      end else if (bus.Hreadyout) begin
        w = rr(bus.Hreq, lst);
        if (w >= 0) begin
          own = w; lst = w; bts = 0; drn = 1'b0;
        end else begin
          drn = 1'b0;
        end
      end
      m_own <= own; m_prev <= prv; m_last <= lst; m_beats <= bts; m_drain <= drn;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Tenure monitor: owners in grant order, tenure lengths, idle gaps before each grant.
  int q_own[$], q_len[$], q_gap[$];
  int run = 0, gap = 0;
  bit gv_prev = 1'b0;

  task automatic clear_mon();
    q_own.delete(); q_len.delete(); q_gap.delete();
    run = 0; gap = 0; gv_prev = 1'b0;
  endtask

  task automatic monitor();
    if (bus.grant_valid) begin
      if (!gv_prev) begin
        q_own.push_back(int'(bus.Hmaster));
        q_gap.push_back(gap);
        run = 0;
      end
      run++;
      gap = 0;
    end else begin
      if (gv_prev) q_len.push_back(run);
      gap++;
    end
    gv_prev = bus.grant_valid;
  endtask

  task automatic compare();
    logic [NM-1:0] eg;
    int em;
    if (m_own >= 0)   begin eg = NM'(1) << m_own; em = m_own;  end
    else if (m_drain) begin eg = '0;              em = m_prev; end
    else              begin eg = NM'(1);          em = 0;      end
    chk("Hgrant",      int'(bus.Hgrant),      int'(eg));
    chk("Hmaster",     int'(bus.Hmaster),     em);
    chk("grant_valid", int'(bus.grant_valid), (m_own >= 0) ? 1 : 0);
    chk("grant_onehot", ($countones(bus.Hgrant) <= 1) ? 1 : 0, 1);
  endtask

  task automatic step(input logic [NM-1:0] req, input logic [1:0] tr, input logic rdy);
    @(negedge Hclk);
    compare();
    monitor();
    bus.Hreq = req; bus.Htrans = tr; bus.Hreadyout = rdy;
  endtask

  task automatic do_reset();
    Hresetn = 1'b0;
    step('0, HTRANS_IDLE, 1'b1);
    step('0, HTRANS_IDLE, 1'b1);
    Hresetn = 1'b1;
    clear_mon();
  endtask

  int exp_own[5] = '{0, 1, 2, 3, 0};
  logic [1:0] burst39[11] = '{HTRANS_NONSEQ, HTRANS_SEQ, HTRANS_BUSY, HTRANS_SEQ,
                              HTRANS_BUSY, HTRANS_BUSY, HTRANS_SEQ, HTRANS_SEQ,
                              HTRANS_SEQ, HTRANS_SEQ, HTRANS_SEQ};
  logic [NM-1:0] rq;

  initial begin
    Hresetn = 1'b0;
    bus.Hreq = '0; bus.Htrans = HTRANS_IDLE; bus.Hreadyout = 1'b1;
    repeat (3) step('0, HTRANS_IDLE, 1'b1);
    Hresetn = 1'b1;
    clear_mon();

    // Idle after reset: parked on master 0, never a real grant.
    repeat (20) step('0, HTRANS_IDLE, 1'b1);
    chk("idle_park_grant", int'(bus.Hgrant), 1);
    chk("idle_no_tenure", q_own.size(), 0);

    // All request, streaming NONSEQ: 0,1,2,3,0 with 8-cycle tenures, 1-cycle gaps.
    clear_mon();
    repeat (45) step(4'b1111, HTRANS_NONSEQ, 1'b1);
    chk("rr_ntenures", (q_own.size() >= 5) ? 1 : 0, 1);
    if (q_own.size() >= 5) begin
      for (int i = 0; i < 5; i++) chk($sformatf("rr_owner%0d", i), q_own[i], exp_own[i]);
      for (int i = 0; i < 4; i++) chk($sformatf("rr_len%0d", i), q_len[i], 8);
      for (int i = 1; i < 5; i++) chk($sformatf("rr_gap%0d", i), q_gap[i], 1);
    end

    // Master 2 drops request mid-burst: tenure runs through the last SEQ.
    do_reset();
    step(4'b0100, HTRANS_IDLE,   1'b1);
    step(4'b0100, HTRANS_NONSEQ, 1'b1);
    repeat (3) step(4'b0000, HTRANS_SEQ, 1'b1);
    repeat (4) step(4'b0000, HTRANS_IDLE, 1'b1);
    chk("burst_owner", (q_own.size() == 1) ? q_own[0] : -1, 2);
    chk("burst_len", (q_len.size() == 1) ? q_len[0] : -1, 5);
    chk("burst_then_park", int'(bus.Hgrant), 1);

    // SWITCH stalled by Hreadyout=0: five stall cycles plus the exit cycle.
    do_reset();
    step(4'b0010, HTRANS_IDLE,   1'b1);
    step(4'b0010, HTRANS_NONSEQ, 1'b1);
    step(4'b1000, HTRANS_IDLE,   1'b1);
    repeat (5) step(4'b1000, HTRANS_IDLE, 1'b0);
    repeat (3) step(4'b1000, HTRANS_IDLE, 1'b1);
    chk("stall_ntenures", q_own.size(), 2);
    if (q_own.size() == 2) begin
      chk("stall_owner0", q_own[0], 1);
      chk("stall_owner1", q_own[1], 3);
      chk("stall_len0",   q_len[0], 2);
      chk("stall_gap",    q_gap[1], 6);
    end
    chk("stall_grant_m3", int'(bus.Hgrant), 8);

    // Async reset mid-tenure of master 3, then master 0 wins first.
    do_reset();
    step(4'b1000, HTRANS_IDLE, 1'b1);
    repeat (3) step(4'b1001, HTRANS_NONSEQ, 1'b1);
    @(posedge Hclk);
    #1 Hresetn = 1'b0;
    #1;
    chk("rst_grant", int'(bus.Hgrant), 1);
    chk("rst_valid", int'(bus.grant_valid), 0);
    chk("rst_master", int'(bus.Hmaster), 0);
    step(4'b1001, HTRANS_IDLE, 1'b1);
    Hresetn = 1'b1;
    clear_mon();
    repeat (3) step(4'b1001, HTRANS_IDLE, 1'b1);
    chk("rst_first_owner", (q_own.size() >= 1) ? q_own[0] : -1, 0);

    // BUSY inside master 1's burst: 8 real beats, release at following IDLE,
    // then sole requester is re-granted after one SWITCH cycle.
    do_reset();
    step(4'b0010, HTRANS_IDLE, 1'b1);
    for (int i = 0; i < 11; i++) step(4'b0010, burst39[i], 1'b1);
    repeat (4) step(4'b0010, HTRANS_IDLE, 1'b1);
    chk("busy_len", (q_len.size() >= 1) ? q_len[0] : -1, 12);
    chk("busy_regrant_owner", (q_own.size() >= 2) ? q_own[1] : -1, 1);
    chk("busy_regrant_gap", (q_gap.size() >= 2) ? q_gap[1] : -1, 1);

    // Random traffic against the model.
    do_reset();
    rq = '0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) rq = NM'($urandom_range(0, (1 << NM) - 1));
      if ($urandom_range(0, 499) == 0) do_reset();
      step(rq, 2'($urandom_range(0, 3)), ($urandom_range(0, 3) != 0));
    end
    step('0, HTRANS_IDLE, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
